// File: rtl/tdm_demux5to1_3bit.sv
// rtl/tdm_demux5to1_3bit.sv - 5-channel TDM demultiplexer with frame lock
//
// Receives a serialized stream of WIDTH-bit symbols, one slot per valid beat,
// slot 0 marked by sync. Locks onto the frame, tracks the slot index and
// rebuilds channels U..Y into registered outputs.
//
// Optional feature macro: TDM_SHADOW_EN
//   defined   : beats land in shadow registers; U..Y update together on the
//               edge that raises frame_done (no mixed-frame outputs).
//   undefined : each channel output updates on the edge its slot is accepted.
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   M          in   serialized symbol (WIDTH)
//   valid      in   M/sync meaningful this cycle
//   sync       in   beat is slot 0 (qualified by valid)
//   U..Y       out  recovered channels, slots 0..4 (WIDTH, registered)
//   S2,S1,S0   out  next expected slot index (0..4)
//   locked     out  frame alignment held
//   frame_done out  1-cycle pulse after slot 4 accepted while locked
//   sync_err   out  1-cycle pulse on sync seen at slot != 0 while locked

module tdm_demux5to1_3bit #(
  parameter int WIDTH      = 3,
  parameter int MISS_LIMIT = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] M,
  input  logic             valid,
  input  logic             sync,
  output logic [WIDTH-1:0] U,
  output logic [WIDTH-1:0] V,
  output logic [WIDTH-1:0] W,
  output logic [WIDTH-1:0] X,
  output logic [WIDTH-1:0] Y,
  output logic             S0,
  output logic             S1,
  output logic             S2,
  output logic             locked,
  output logic             frame_done,
  output logic             sync_err
);

  typedef enum logic {HUNT = 1'b0, LOCK = 1'b1} state_t;

  localparam logic [2:0] MISS_LIM = 3'(MISS_LIMIT);

  state_t           state_q, state_d;
  logic [2:0]       slot_q, slot_d;
  logic [2:0]       miss_q, miss_d;
  logic             frame_done_q, frame_done_d;
  logic             sync_err_q, sync_err_d;
  logic [WIDTH-1:0] u_q, v_q, w_q, x_q, y_q;

  // Write strobe and target slot for the current beat.
  logic             wr_en;
  logic [2:0]       wr_slot;

`ifdef TDM_SHADOW_EN
  // Slots 0..3 are staged; slot 4 arrives on the transfer edge itself and
  // goes straight to Y, so it needs no shadow.
  logic [WIDTH-1:0] sh_u_q, sh_v_q, sh_w_q, sh_x_q;
`endif

  always_comb begin
    state_d      = state_q;
    slot_d       = slot_q;
    miss_d       = miss_q;
    frame_done_d = 1'b0;
    sync_err_d   = 1'b0;
    wr_en        = 1'b0;
    wr_slot      = 3'd0;

    if (valid) begin
      case (state_q)
        HUNT: begin
          if (sync) begin
            wr_en   = 1'b1;
            slot_d  = 3'd1;
            miss_d  = 3'd0;
            state_d = LOCK;
          end
        end

        LOCK: begin
          if (slot_q == 3'd0) begin
            if (sync) begin
              wr_en  = 1'b1;
              slot_d = 3'd1;
              miss_d = 3'd0;
            end else if (3'(miss_q + 3'd1) >= MISS_LIM) begin
              // Too many frames without sync: give up, discard this beat.
              state_d = HUNT;
              slot_d  = 3'd0;
              miss_d  = MISS_LIM;
            end else begin
              // Missing sync tolerated: keep the data, count the miss.
              wr_en  = 1'b1;
              slot_d = 3'd1;
              miss_d = 3'(miss_q + 3'd1);
            end
          end else if (sync) begin
            // Early sync: abandon the partial frame and restart at slot 0.
            sync_err_d = 1'b1;
            wr_en      = 1'b1;
            slot_d     = 3'd1;
            miss_d     = 3'd0;
          end else begin
            wr_en   = 1'b1;
            wr_slot = slot_q;
            if (slot_q == 3'd4) begin
              slot_d       = 3'd0;
              frame_done_d = 1'b1;
            end else begin
              slot_d = 3'(slot_q + 3'd1);
            end
          end
        end

        default: begin
          state_d = HUNT;
          slot_d  = 3'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= HUNT;
      slot_q       <= 3'd0;
      miss_q       <= 3'd0;
      frame_done_q <= 1'b0;
      sync_err_q   <= 1'b0;
      u_q          <= '0;
      v_q          <= '0;
      w_q          <= '0;
      x_q          <= '0;
      y_q          <= '0;
`ifdef TDM_SHADOW_EN
      sh_u_q       <= '0;
      sh_v_q       <= '0;
      sh_w_q       <= '0;
      sh_x_q       <= '0;
`endif
    end else begin
      state_q      <= state_d;
      slot_q       <= slot_d;
      miss_q       <= miss_d;
      frame_done_q <= frame_done_d;
      sync_err_q   <= sync_err_d;
`ifdef TDM_SHADOW_EN
      if (wr_en) begin
        case (wr_slot)
          3'd0:    sh_u_q <= M;
          3'd1:    sh_v_q <= M;
          3'd2:    sh_w_q <= M;
          3'd3:    sh_x_q <= M;
          default: ;
        endcase
      end
      if (frame_done_d) begin
        u_q <= sh_u_q;
        v_q <= sh_v_q;
        w_q <= sh_w_q;
        x_q <= sh_x_q;
        y_q <= M;
      end
`else
      if (wr_en) begin
        case (wr_slot)
          3'd0:    u_q <= M;
          3'd1:    v_q <= M;
          3'd2:    w_q <= M;
          3'd3:    x_q <= M;
          3'd4:    y_q <= M;
          default: ;
        endcase
      end
`endif
    end
  end

  assign U          = u_q;
  assign V          = v_q;
  assign W          = w_q;
  assign X          = x_q;
  assign Y          = y_q;
  assign S0         = slot_q[0];
  assign S1         = slot_q[1];
  assign S2         = slot_q[2];
  assign locked     = (state_q == LOCK);
  assign frame_done = frame_done_q;
  assign sync_err   = sync_err_q;

endmodule

// File: doc/tdm_demux5to1_3bit.md
# tdm_demux5to1_3bit

Time-division demultiplexer, the receiving end of a 5:1 3-bit mux link. It takes a serialized stream of WIDTH-bit symbols, one channel slot per valid beat, with slot 0 marked by `sync`. It locks onto the frame, tracks the slot index, and rebuilds the five channels U, V, W, X, Y into registered outputs. It sits downstream of the 5-to-1 mux path and recovers the parallel words that the mux select sequence scanned out.

## Interface
Parameters:
- `WIDTH`, default 3: symbol and channel width.
- `MISS_LIMIT`, default 2: number of consecutive frames with `sync` missing at slot 0 before lock is dropped. Legal range 1–7.

Ports:
- `clk`  in  1: single clock. All logic is rising-edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `M`  in  WIDTH: serialized symbol.
- `valid`  in  1: `M` and `sync` are meaningful this cycle (one beat).
- `sync`  in  1: marks the beat as slot 0 (U). Qualified by `valid`.
- `U`, `V`, `W`, `X`, `Y`  out  WIDTH each: recovered channels for slots 0–4. Registered.
- `S0`, `S1`, `S2`  out  1 each: next expected slot index, {S2,S1,S0}, range 0–4.
- `locked`  out  1: frame alignment held.
- `frame_done`  out  1: one-cycle pulse after slot 4 is accepted while locked.
- `sync_err`  out  1: one-cycle pulse when `sync` arrives at a slot other than 0 while locked.

## Operation
- Reset value of every output is 0. State is HUNT, slot index 0, miss count 0. Internal shadow registers also reset to 0.
- State machine has two states, HUNT and LOCK.
- **HUNT**
  - Beats with `valid`=1 and `sync`=0 are discarded.
  - A beat with `valid`=1 and `sync`=1 writes `M` to slot 0. Slot index becomes 1, miss count 0, state becomes LOCK, and `locked` rises.
- **LOCK**
  - Each beat with `valid`=1 writes `M` to the channel at the current slot index. The index then increments, wrapping 4→0.
  - When slot 4 is accepted, `frame_done` pulses.
  - Beat at slot 0 with `sync`=1: miss count clears.
  - Beat at slot 0 with `sync`=0: data is still written to U and miss count increments. When the count reaches MISS_LIMIT, the beat is discarded instead, state returns to HUNT, `locked` drops, and the slot index returns to 0.
  - Beat at slot ≠0 with `sync`=1: `sync_err` pulses and the block realigns. `M` is written to U, slot index becomes 1, miss count clears, and `locked` stays 1. The partial frame is abandoned, and `frame_done` does not pulse for it.
- `valid`=0 holds all state. `sync` is ignored when `valid`=0.
- Channels not written in the current frame hold their previous values.
- Arithmetic:
  - Slot index is 3 bits; values 5–7 are unreachable.
  - Miss count is 3 bits and saturates at MISS_LIMIT.
  - No width conversion; `M` is copied bit-exact.

## Timing
- Latency is 1 cycle. A beat accepted at edge k shows on its channel output and on S0–S2 after edge k.
- `frame_done` and `sync_err` are high for exactly the cycle after their triggering edge.
- Back-to-back valid beats are accepted every cycle. There is no backpressure.
- `rst_n` assertion mid-frame clears everything immediately, without waiting for `clk`. The partial frame is lost.
- After `rst_n` deasserts, the block is in HUNT, and the first `valid` & `sync` beat is accepted on the next edge.

## Configuration
- `TDM_SHADOW_EN`, when defined:
  - Beats write internal shadow registers instead of the channel outputs.
  - U–Y load from the shadow registers together, on the same edge that raises `frame_done`.
  - Outputs never show a mix of two frames.
  - On a `sync_err` realign or a drop to HUNT, the shadow contents are not transferred.
- When not defined:
  - No shadow registers exist.
  - Each channel output updates on the edge its slot is accepted.

## Test plan
- Reset, then beats `sync`=1/M=1 followed by M=2,3,4,5 on consecutive cycles → U=1, V=2, W=3, X=4, Y=5. `frame_done` pulses once. `locked`=1. {S2,S1,S0}=0.
- Idle gaps: the same frame with `valid`=0 cycles interleaved → identical outputs. The slot index holds across the gaps.
- Realign: frame in progress at slot 2, then `sync`=1/M=6 → `sync_err` pulses, U=6, slot index 1, no `frame_done`.
- Missed sync with MISS_LIMIT=2 → the first frame lacking `sync` still updates U. The second drops `locked` and leaves U unchanged. The next `sync` beat relocks.
- Assert `rst_n`=0 mid-frame → all outputs 0 immediately, without a clock edge. Beats without `sync` afterwards are ignored.
- With `TDM_SHADOW_EN`: check that U–Y stay at the old frame until the edge that raises `frame_done`, then all change together.
